// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op codes, FSM states
// and the iteration counter sizing helper.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MADD  = 4'b0110;
    localparam logic [3:0] OP_MADDU = 4'b0111;
    localparam logic [3:0] OP_MSUB  = 4'b1000;
    localparam logic [3:0] OP_MSUBU = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    // Counter must reach MUL_LAT (accumulate ops) and WIDTH-1 (divide steps).
    function automatic int cnt_width(input int width, input int mul_lat);
        int m;
        m = (mul_lat > width) ? mul_lat + 1 : width + 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes; one quotient bit
// per step, WIDTH steps per divide. Sign handling lives in the parent.
module muldiv_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
    logic [WIDTH:0]   trial;

    // Dividend bits shift out of quot_q's MSB into the partial remainder.
    always_comb begin
        trial  = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_d  = rem_q;
        quot_d = quot_q;
        dvs_d  = dvs_q;
        if (load_i) begin
            rem_d  = '0;
            quot_d = dividend_i;
            dvs_d  = divisor_i;
        end else if (step_i) begin
            if (!trial[WIDTH]) begin
                rem_d  = trial[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: pipelined multiply, iterative divide, flushable.
// Define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = cnt_width(WIDTH, MUL_LAT);
    localparam int PW    = 2 * WIDTH;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, mul_last;
    logic             busy_q, done_q, sgn_q, acc_q, sub_q;
    logic [WIDTH-1:0] hi_q, lo_q, a_q, b_q;
    logic [PW-1:0]    acc_sum_q;
    logic [PW-1:0]    prod_pipe_q [MUL_LAT];

    logic             is_mul, is_div, is_sgn, is_acc, is_sub, accept;
    logic [PW-1:0]    a_ext, b_ext;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, quot, rem;
    logic             q_neg, r_neg;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_sgn = 1'b0;
        is_acc = 1'b0;
        is_sub = 1'b0;
        case (op_i)
            OP_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_acc = 1'b1; is_sgn = 1'b1; end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_sgn = 1'b1; end
            OP_MSUBU: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign accept   = start_i && !busy_q && !flush_i;
    assign a_ext    = {{WIDTH{is_sgn & a_i[WIDTH-1]}}, a_i};
    assign b_ext    = {{WIDTH{is_sgn & b_i[WIDTH-1]}}, b_i};
    assign dvd_mag  = (is_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    assign dvs_mag  = (is_sgn && b_i[WIDTH-1]) ? -b_i : b_i;
    assign q_neg    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign r_neg    = sgn_q & a_q[WIDTH-1];
    assign mul_last = acc_q ? CNT_W'(MUL_LAT) : CNT_W'(MUL_LAT - 1);

    // Free-running product delay line; the FSM picks the tap MUL_LAT-1 edges after accept.
    always_ff @(posedge clk) begin
        prod_pipe_q[0] <= a_ext * b_ext;
        for (int i = 1; i < MUL_LAT; i++) prod_pipe_q[i] <= prod_pipe_q[i-1];
    end

    muldiv_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept && is_div),
        .step_i     (state_q == S_DIV),
        .dividend_i (dvd_mag),
        .divisor_i  (dvs_mag),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
            acc_sum_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    cnt_q <= '0;
                    a_q   <= a_i;
                    b_q   <= b_i;
                    sgn_q <= is_sgn;
                    acc_q <= is_acc;
                    sub_q <= is_sub;
                    if (is_mul) begin
                        state_q <= S_MUL;
                        busy_q  <= 1'b1;
                    end else if (is_div) begin
                        state_q <= S_DIV;
                        busy_q  <= 1'b1;
                    end else if (op_i == OP_MTHI) begin
                        hi_q <= a_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_q <= a_i;
                    end
                end
                S_MUL: if (flush_i) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end else if (cnt_q == mul_last) begin
                    {hi_q, lo_q} <= acc_q ? acc_sum_q : prod_pipe_q[MUL_LAT-1];
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end else begin
                    // Last capture (cnt == MUL_LAT-1) is the one the accumulate cycle uses.
                    cnt_q     <= cnt_q + CNT_W'(1);
                    acc_sum_q <= sub_q ? {hi_q, lo_q} - prod_pipe_q[MUL_LAT-1]
                                       : {hi_q, lo_q} + prod_pipe_q[MUL_LAT-1];
                end
                S_DIV: if (flush_i) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_q <= S_FIX;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_FIX: if (flush_i) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    if (b_q == '0) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= r_neg ? -rem : rem;
                        lo_q <= q_neg ? -quot : quot;
                    end
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32, MUL_LAT=5); honours MULDIV_MADD_EN.
module tb_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [3:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done;
    int           n_vec = 0;
    int           n_err = 0;

    muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one request for a single cycle, then scramble a/b to prove they are latched.
    task automatic kick(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 4'hF;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int           cyc;
        logic         bad;
        logic [W-1:0] h0, l0;
        cyc = 0;
        bad = 1'b0;
        h0  = hi;
        l0  = lo;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (!busy || hi !== h0 || lo !== l0) bad = 1'b1;
        end
        chk({tag, "_lat"}, W'(cyc), W'(exp_lat));
        chk({tag, "_hold"}, W'(bad), '0);
        chk({tag, "_busy_fall"}, W'(busy), '0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, W'(done), '0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 4'h0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);

        kick(4'b0000, 32'hFFFF_FFFD, 32'd7);
        chk("mult_busy_rise", W'(busy), 32'd1);
        wait_done("mult", LAT);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        kick(4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", LAT);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        kick(4'b0010, 32'hFFFF_FFF9, 32'd2);
        wait_done("div", 33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        kick(4'b0010, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_negb", 33);
        chk("div_negb_lo", lo, 32'hFFFF_FFFD);
        chk("div_negb_hi", hi, 32'h0000_0001);

        kick(4'b0011, 32'hFFFF_FFF9, 32'd2);
        wait_done("divu", 33);
        chk("divu_lo", lo, 32'h7FFF_FFFC);
        chk("divu_hi", hi, 32'h0000_0001);

        kick(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 33);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0000_0000);

        kick(4'b0011, 32'd5, 32'd0);
        wait_done("divu_z", 33);
        chk("divu_z_hi", hi, 32'h0000_0005);
        chk("divu_z_lo", lo, 32'hFFFF_FFFF);

        // Flush at cycle 10 of a divide, then MTHI the next cycle.
        kick(4'b0011, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", W'(busy), '0);
        chk("flush_done", W'(done), '0);
        chk("flush_hi", hi, 32'h0000_0005);
        chk("flush_lo", lo, 32'hFFFF_FFFF);
        kick(4'b0100, 32'h0000_1234, 32'd0);
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_busy", W'(busy), '0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("flush_no_done", W'(seen), '0);
        chk("flush_lo_kept", lo, 32'hFFFF_FFFF);

        // MTLO and a second MULT while MULTU is in flight are both dropped.
        kick(4'b0001, 32'h0001_0000, 32'h0001_0000);
        start = 1'b1; op = 4'b0101; a = 32'h0000_DEAD;
        @(negedge clk);
        op = 4'b0000; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 4'hF;
        wait_done("multu_busy", LAT - 2);
        chk("multu_busy_hi", hi, 32'h0000_0001);
        chk("multu_busy_lo", lo, 32'h0000_0000);

        // start together with flush in IDLE is not accepted.
        start = 1'b1; flush = 1'b1; op = 4'b0000; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 4'hF;
        chk("stflush_busy", W'(busy), '0);
        repeat (LAT + 1) @(negedge clk);
        chk("stflush_hi", hi, 32'h0000_0001);
        chk("stflush_lo", lo, 32'h0000_0000);

        kick(4'b0100, 32'h0000_0000, 32'd0);
        kick(4'b0101, 32'hFFFF_FFFF, 32'd0);
`ifdef MULDIV_MADD_EN
        kick(4'b0111, 32'd1, 32'd1);
        wait_done("maddu", LAT + 1);
        chk("maddu_hi", hi, 32'h0000_0001);
        chk("maddu_lo", lo, 32'h0000_0000);
        kick(4'b1000, 32'd2, 32'hFFFF_FFFF);
        wait_done("msub", LAT + 1);
        chk("msub_hi", hi, 32'h0000_0001);
        chk("msub_lo", lo, 32'h0000_0002);
`else
        kick(4'b0111, 32'd1, 32'd1);
        chk("maddu_nop_busy", W'(busy), '0);
        repeat (LAT + 2) @(negedge clk);
        chk("maddu_nop_hi", hi, 32'h0000_0000);
        chk("maddu_nop_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a multiply wins.
        kick(4'b0000, 32'd3, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", W'(busy), '0);
        chk("rst_mid_hi", hi, '0);
        chk("rst_mid_lo", lo, '0);
        seen = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("rst_mid_no_done", W'(seen), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
